// File: rtl/p_beid_interconnect_f0_ahb_mtx_qos_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// p_beid_interconnect_f0_ahb_mtx_qos_arbiter_pkg
// Shared definitions for the bus-matrix output-stage QoS arbiter:
//   - AHB HTRANS / HBURST encodings
//   - port count and port index width
//   - burst_len_m1(): beats remaining after a NONSEQ for a given HBURST
//   - rr_pick():      first set bit of a port mask in round-robin order
// ---------------------------------------------------------------------------
package p_beid_interconnect_f0_ahb_mtx_qos_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // Beats still to come after the NONSEQ beat. Undefined-length INCR is
  // protected for its first 4 beats only, so it behaves like INCR4 here.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    logic [3:0] len;
    case (hburst)
      HBURST_INCR, HBURST_WRAP4, HBURST_INCR4: len = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:              len = 4'd7;
      HBURST_WRAP16, HBURST_INCR16:            len = 4'd15;
      default:                                 len = 4'd0;
    endcase
    return len;
  endfunction

  // Search ports start, start+1, ... (mod NUM_PORTS) and return the first
  // one whose mask bit is set. Returns start when the mask is empty.
  function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] mask,
                                                input logic [PORT_W-1:0]    start);
    logic [PORT_W-1:0] idx;
    logic [PORT_W-1:0] pick;
    logic              found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = start + PORT_W'(i);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/p_beid_interconnect_f0_ahb_mtx_burst_tracker.sv
// ---------------------------------------------------------------------------
// p_beid_interconnect_f0_ahb_mtx_burst_tracker
// Tracks how many beats of the granted stage's burst are still outstanding so
// the arbiter can hold the grant until the burst (or the first 4 beats of an
// INCR) has completed.
// Ports:
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   HREADYM            transfer accepted; the counter only moves when high
//   HSELM, HTRANSM,
//   HBURSTM            select / transfer type / burst type of granted stage
//   next_hold          beats remain after the current transfer completes
// ---------------------------------------------------------------------------
module p_beid_interconnect_f0_ahb_mtx_burst_tracker
  import p_beid_interconnect_f0_ahb_mtx_qos_arbiter_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       next_hold
);

  logic [3:0] remain_reg;
  logic [3:0] remain_next;

  always_comb begin
    remain_next = remain_reg;
    if (!HSELM) begin
      remain_next = 4'd0;
    end else begin
      case (HTRANSM)
        HTRANS_NONSEQ: remain_next = burst_len_m1(HBURSTM);
        HTRANS_SEQ:    remain_next = (remain_reg == 4'd0) ? 4'd0 : remain_reg - 4'd1;
        HTRANS_BUSY:   remain_next = remain_reg;
        default:       remain_next = 4'd0;
      endcase
    end
  end

  assign next_hold = (remain_next != 4'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remain_reg <= 4'd0;
    end else if (HREADYM) begin
      remain_reg <= remain_next;
    end
  end

endmodule

// File: rtl/p_beid_interconnect_f0_ahb_mtx_qos_arbiter.sv
// ---------------------------------------------------------------------------
// p_beid_interconnect_f0_ahb_mtx_qos_arbiter
// Output-stage arbiter of a shared AHB slave port. Grants one of four input
// ports per address phase by 2-bit priority with round-robin among equals,
// holds the grant across bursts and locked sequences, and optionally promotes
// ports that have waited AGE_LIMIT accepted transfers.
// Build option: define P_BEID_AHB_MTX_QOS_STARVE_EN to include the age
// counters and the starvation path; otherwise starved is tied to 0.
// Ports:
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   req_port[n]        request from input port n
//   pri_port[2n+1:2n]  priority of port n (3 highest)
//   HREADYM            output transfer done; all state updates qualified by it
//   HSELM, HTRANSM, HBURSTM, HMASTLOCKM   control of the granted stage
//   addr_in_port       granted port index
//   no_port            no port granted
//   starved            current grant came from the starvation path
// ---------------------------------------------------------------------------
module p_beid_interconnect_f0_ahb_mtx_qos_arbiter
  import p_beid_interconnect_f0_ahb_mtx_qos_arbiter_pkg::*;
#(
  parameter int AGE_W     = 4,
  parameter int AGE_LIMIT = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [NUM_PORTS-1:0]  req_port,
  input  logic [2*NUM_PORTS-1:0] pri_port,
  input  logic                  HREADYM,
  input  logic                  HSELM,
  input  logic [1:0]            HTRANSM,
  input  logic [2:0]            HBURSTM,
  input  logic                  HMASTLOCKM,
  output logic [PORT_W-1:0]     addr_in_port,
  output logic                  no_port,
  output logic                  starved
);

  logic [PORT_W-1:0]    addr_reg;
  logic [PORT_W-1:0]    addr_next;
  logic                 no_port_reg;
  logic                 no_port_next;
  logic                 next_hold;
  logic                 keep_grant;
  logic [PORT_W-1:0]    rr_start;
  logic [1:0]           pri_arr [NUM_PORTS];
  logic [1:0]           max_pri;
  logic [NUM_PORTS-1:0] top_mask;

  p_beid_interconnect_f0_ahb_mtx_burst_tracker u_burst_tracker (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HREADYM   (HREADYM),
    .HSELM     (HSELM),
    .HTRANSM   (HTRANSM),
    .HBURSTM   (HBURSTM),
    .next_hold (next_hold)
  );

  assign keep_grant = HMASTLOCKM || next_hold;

  // Current port is checked last; with nothing granted the search begins at 0.
  assign rr_start = no_port_reg ? '0 : addr_reg + PORT_W'(1);

  always_comb begin
    max_pri = 2'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_port[i] && (pri_arr[i] > max_pri)) begin
        max_pri = pri_arr[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pri
    assign pri_arr[gi]  = pri_port[2*gi +: 2];
    assign top_mask[gi] = req_port[gi] && (pri_arr[gi] == max_pri);
  end

`ifdef P_BEID_AHB_MTX_QOS_STARVE_EN
  logic [NUM_PORTS-1:0] starve_mask;
  logic                 starved_reg;
  logic                 starved_next;

  // A port ages for every accepted transfer it spends requesting without
  // being granted; it clears as soon as it is granted or stops requesting.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_age
    logic [AGE_W-1:0] age_reg;
    logic             granted_next;

    assign granted_next     = !no_port_next && (addr_next == PORT_W'(gi));
    assign starve_mask[gi]  = req_port[gi] && (age_reg == AGE_W'(AGE_LIMIT));

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        age_reg <= '0;
      end else if (HREADYM) begin
        if (req_port[gi] && !granted_next) begin
          if (age_reg != AGE_W'(AGE_LIMIT)) begin
            age_reg <= age_reg + AGE_W'(1);
          end
        end else begin
          age_reg <= '0;
        end
      end
    end
  end

  // starved follows the grant decision: kept through a hold, set by the
  // starvation path, cleared by any other decision.
  always_comb begin
    starved_next = 1'b0;
    if (keep_grant) begin
      starved_next = starved_reg;
    end else if (|starve_mask) begin
      starved_next = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      starved_reg <= 1'b0;
    end else if (HREADYM) begin
      starved_reg <= starved_next;
    end
  end

  assign starved = starved_reg;
`else
  logic unused_cfg;
  assign unused_cfg = (AGE_W > 0) && (AGE_LIMIT > 0);
  assign starved    = 1'b0;
`endif

  always_comb begin
    addr_next    = addr_reg;
    no_port_next = no_port_reg;
    if (keep_grant) begin
      // Locked sequence or burst in progress: grant (or no_port) unchanged.
      addr_next    = addr_reg;
      no_port_next = no_port_reg;
    end
`ifdef P_BEID_AHB_MTX_QOS_STARVE_EN
    else if (|starve_mask) begin
      addr_next    = rr_pick(starve_mask, rr_start);
      no_port_next = 1'b0;
    end
`endif
    else if (|req_port) begin
      addr_next    = rr_pick(top_mask, rr_start);
      no_port_next = 1'b0;
    end else if (!no_port_reg && HSELM) begin
      // Idle but the granted stage still selects the slave: park on it.
      addr_next    = addr_reg;
      no_port_next = 1'b0;
    end else begin
      // Release; the index is left where it was.
      no_port_next = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_reg    <= '0;
      no_port_reg <= 1'b1;
    end else if (HREADYM) begin
      addr_reg    <= addr_next;
      no_port_reg <= no_port_next;
    end
  end

  assign addr_in_port = addr_reg;
  assign no_port      = no_port_reg;

endmodule

// File: tb/tb_p_beid_interconnect_f0_ahb_mtx_qos_arbiter.sv
// ---------------------------------------------------------------------------
// tb_p_beid_interconnect_f0_ahb_mtx_qos_arbiter
// Directed bench for the output-stage QoS arbiter. Each step drives inputs,
// waits one HCLK edge and compares {starved, no_port, addr_in_port} with a
// hand-computed value. Starvation expectations follow
// P_BEID_AHB_MTX_QOS_STARVE_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_p_beid_interconnect_f0_ahb_mtx_qos_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] req_port;
  logic [7:0] pri_port;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic       starved;

  int errors = 0;
  int checks = 0;

  p_beid_interconnect_f0_ahb_mtx_qos_arbiter #(
    .AGE_W     (4),
    .AGE_LIMIT (12)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
    .pri_port     (pri_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .starved      (starved)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // exp = {starved, no_port, addr[1:0]}
  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {starved, no_port, addr_in_port};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed st/np/addr=%b required %b", tag, obs, exp);
    end
    $display("[%0t] %s st/np/addr=%b", $time, tag, obs);
  endtask

  initial begin
    logic [1:0] exp_addr;
    logic       exp_st;

    HRESETn    = 1'b0;
    req_port   = 4'b0000;
    pri_port   = 8'h00;
    HREADYM    = 1'b1;
    HSELM      = 1'b1;
    HTRANSM    = T_IDLE;
    HBURSTM    = B_SINGLE;
    HMASTLOCKM = 1'b0;

    repeat (2) tick();
    check("reset", 4'b0_1_00);
    HRESETn = 1'b1;

    // No request: stays ungranted.
    tick(); check("idle_no_req", 4'b0_1_00);
    // Single requester, one-cycle latency.
    req_port = 4'b0100;
    tick(); check("single_req_p2", 4'b0_0_10);
    // Request drops, HSELM high: park on current port.
    req_port = 4'b0000;
    tick(); check("no_req_park", 4'b0_0_10);
    // HSELM low: release, index unchanged.
    HSELM = 1'b0;
    tick(); check("release_keep_idx", 4'b0_1_10);

    // Round robin among equal priorities, search from port 0 after release.
    HSELM    = 1'b1;
    req_port = 4'b1111;
    HTRANSM  = T_NONSEQ;
    HBURSTM  = B_SINGLE;
    for (int i = 0; i < 5; i++) begin
      exp_addr = 2'(i % 4);
      tick(); check($sformatf("rr_%0d", i), {2'b00, exp_addr});
    end

    // Clear requests (ages cleared), parks on port 0.
    req_port = 4'b0000;
    HTRANSM  = T_IDLE;
    tick(); check("prio_clear", 4'b0_0_00);

    // Port 1 at priority 3 dominates; starvation promotes 2,3,0 in RR order.
    pri_port = 8'b00_00_11_00;
    req_port = 4'b1111;
    HTRANSM  = T_NONSEQ;
    for (int t = 1; t <= 16; t++) begin
      exp_addr = 2'd1;
      exp_st   = 1'b0;
`ifdef P_BEID_AHB_MTX_QOS_STARVE_EN
      if (t == 13) begin exp_addr = 2'd2; exp_st = 1'b1; end
      if (t == 14) begin exp_addr = 2'd3; exp_st = 1'b1; end
      if (t == 15) begin exp_addr = 2'd0; exp_st = 1'b1; end
`endif
      tick(); check($sformatf("prio_t%0d", t), {exp_st, 1'b0, exp_addr});
    end

    // Drop requests: park on port 1, starved cleared.
    req_port = 4'b0000;
    HTRANSM  = T_IDLE;
    tick(); check("prio_drop", 4'b0_0_01);

    // Port 0 granted, then INCR8 while port 3 requests at priority 3.
    pri_port = 8'h00;
    req_port = 4'b0001;
    tick(); check("burst_setup", 4'b0_0_00);
    pri_port = 8'b11_00_00_00;
    req_port = 4'b1001;
    HBURSTM  = B_INCR8;
    for (int b = 1; b <= 8; b++) begin
      HTRANSM  = (b == 1) ? T_NONSEQ : T_SEQ;
      exp_addr = (b == 8) ? 2'd3 : 2'd0;
      tick(); check($sformatf("incr8_beat%0d", b), {2'b00, exp_addr});
    end

    // Same burst with two BUSY beats inserted after beat 2.
    req_port = 4'b0001;
    HTRANSM  = T_IDLE;
    tick(); check("busy_setup", 4'b0_0_00);
    req_port = 4'b1001;
    for (int b = 1; b <= 10; b++) begin
      if (b == 1)                 HTRANSM = T_NONSEQ;
      else if (b == 3 || b == 4)  HTRANSM = T_BUSY;
      else                        HTRANSM = T_SEQ;
      exp_addr = (b == 10) ? 2'd3 : 2'd0;
      tick(); check($sformatf("busy_burst_c%0d", b), {2'b00, exp_addr});
    end

    // Locked singles keep port 3 despite other requests.
    pri_port   = 8'h00;
    req_port   = 4'b1111;
    HTRANSM    = T_NONSEQ;
    HBURSTM    = B_SINGLE;
    HMASTLOCKM = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); check($sformatf("lock_c%0d", c), 4'b0_0_11);
    end
    // Lock drops but HREADYM low: frozen.
    HMASTLOCKM = 1'b0;
    HREADYM    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(); check($sformatf("wait_c%0d", c), 4'b0_0_11);
    end
    // Wait state ends: deferred arbitration moves on to port 0.
    HREADYM = 1'b1;
    tick(); check("wait_release", 4'b0_0_00);

    // Port 2 starts an INCR16; reset during beat 5.
    req_port = 4'b0100;
    HTRANSM  = T_IDLE;
    tick(); check("rst_setup", 4'b0_0_10);
    HBURSTM = B_INCR16;
    for (int b = 1; b <= 4; b++) begin
      HTRANSM = (b == 1) ? T_NONSEQ : T_SEQ;
      tick(); check($sformatf("incr16_beat%0d", b), 4'b0_0_10);
    end
    HTRANSM = T_SEQ;
    HRESETn = 1'b0;
    #2;
    check("reset_async", 4'b0_1_00);
    tick(); check("reset_held", 4'b0_1_00);
    HRESETn  = 1'b1;
    // Leftover SEQ would hold if burst state survived reset.
    req_port = 4'b0010;
    tick(); check("post_reset_grant", 4'b0_0_01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
